dmem_bank: RTL

Parametrised, byte-lane-enabled data memory with a valid/ready request channel and a registered response channel. It generalises the single-cycle combinational data memory to configurable data width, depth, base address and read latency. It adds backpressure, per-request error reporting and a debug word port. It sits between the MEM stage / load-store unit and the data address space, and each instance serves one contiguous address window.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_lane.sv | 35 +++
 rtl/dmem_bank.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg: shared defaults and response type for dmem_bank        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dmem_pkg;

  localparam int          c_DATA_W    = 32;
  localparam int          c_DEPTH     = 1024;
  localparam logic [31:0] c_BASE_ADDR = 32'h1001_0000;

  typedef struct packed {
    logic [c_DATA_W-1:0] rdata;
    logic                err;
  } resp_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_lane: one byte-wide column, synchronous write, two async    |
// | read ports (datapath and debug). Contents are not reset.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_lane
  import dmem_pkg::*;
#(
  parameter  int DEPTH = c_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [7:0]       rdata,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [7:0]       dbg_data
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[widx] <= wdata;
    end
  end

  assign rdata    = r_mem[ridx];
  assign dbg_data = r_mem[dbg_idx];

endmodule
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_bank: byte-enabled data memory window with valid/ready      |
// | requests and a registered, backpressured response (1 or 2 cyc).  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_bank
  import dmem_pkg::*;
#(
  parameter  int                DATA_W    = c_DATA_W,
  parameter  int                DEPTH     = c_DEPTH,
  parameter  int                ADDR_W    = 32,
  parameter  logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(c_BASE_ADDR),
  parameter  int                READ_LAT  = 1,
  localparam int                BYTES     = DATA_W / 8,
  localparam int                IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BYTES-1:0]  req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic [IDX_W-1:0]  dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int                c_OFF_W      = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] c_SPAN       = ADDR_W'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(BYTES - 1);

  logic [ADDR_W-1:0] w_offset;
  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic              w_advance;
  logic              w_accept;
  logic [BYTES-1:0]  w_lane_we;
  logic [DATA_W-1:0] w_lane_rdata;

  // Request as seen by the output register: current request or the mid stage
  logic              w_src_valid;
  logic              w_src_we;
  logic              w_src_err;
  logic [IDX_W-1:0]  w_src_idx;

  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  // Unsigned subtraction makes addresses below the window wrap into the range check
  assign w_offset = req_addr - BASE_ADDR;
  assign w_idx    = w_offset[c_OFF_W +: IDX_W];
  assign w_err    = (w_offset >= c_SPAN) || ((w_offset & c_ALIGN_MASK) != '0) ||
                    (req_we && (req_be == '0));

  assign w_advance = !(r_resp_valid && !resp_ready);
  assign req_ready = w_advance;
  assign w_accept  = req_valid && w_advance;
  assign w_lane_we = {BYTES{w_accept && req_we && !w_err}} & req_be;

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    dmem_lane #(.DEPTH(DEPTH)) u_lane (
      .clk      (clk),
      .we       (w_lane_we[i]),
      .widx     (w_idx),
      .wdata    (req_wdata[8*i +: 8]),
      .ridx     (w_src_idx),
      .rdata    (w_lane_rdata[8*i +: 8]),
      .dbg_idx  (dbg_idx),
      .dbg_data (dbg_data[8*i +: 8])
    );
  end

  if (READ_LAT == 2) begin : g_lat2
    logic             r_s1_valid;
    logic             r_s1_we;
    logic             r_s1_err;
    logic [IDX_W-1:0] r_s1_idx;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1_valid <= 1'b0;
        r_s1_we    <= 1'b0;
        r_s1_err   <= 1'b0;
        r_s1_idx   <= '0;
      end else if (w_advance) begin
        r_s1_valid <= w_accept;
        r_s1_we    <= req_we;
        r_s1_err   <= w_err;
        r_s1_idx   <= w_idx;
      end
    end

    // Array is read one edge later; later writes cannot land first since a stall blocks acceptance
    assign w_src_valid = r_s1_valid;
    assign w_src_we    = r_s1_we;
    assign w_src_err   = r_s1_err;
    assign w_src_idx   = r_s1_idx;
  end else begin : g_lat1
    assign w_src_valid = w_accept;
    assign w_src_we    = req_we;
    assign w_src_err   = w_err;
    assign w_src_idx   = w_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else if (w_advance) begin
      r_resp_valid <= w_src_valid;
      r_resp_err   <= w_src_valid && w_src_err;
      r_resp_rdata <= (w_src_valid && !w_src_we && !w_src_err) ? w_lane_rdata : '0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire
